gf_pe_vec: RTL
==============

# gf_pe_vec

Vectorised GF(2^m) processing element: the parametrised successor to the scalar systolic PE used in the key/signature arrays. It operates on LANES field elements per beat, has a configurable-depth multiplier pipeline, and has a per-lane accumulator with in-order effect ordering. It adds a valid/ready stream handshake with backpressure and a latched key coefficient. It sits between the key/vector buffers and the Gauss/eval array controllers as a bulk MAC, scale and drain engine.

## Interface
- GF_BIT, 4, field width m; only 4 or 8 are legal.
- LANES, 4, elements per beat; legal range 1..16.
- MUL_STAGES, 1, register stages after the multiplier; legal range 0..2.
- OP_CODE_LEN, 4, opcode width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  a beat is offered.
- in_ready  out  1  the beat is accepted at this edge when in_valid && in_ready.
- op_in  in  OP_CODE_LEN  opcode for the beat.
- coef_in  in  GF_BIT  scalar coefficient for the beat.
- data_in  in  LANES*GF_BIT  vector; lane i occupies bits [i*GF_BIT +: GF_BIT].
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- op_out  out  OP_CODE_LEN  opcode of the result beat.
- data_out  out  LANES*GF_BIT  result vector.
- nz_mask  out  LANES  bit i = (acc[i] != 0), taken from the registered accumulator.
- illegal_op  out  1  sticky; set when an opcode in 8..15 is accepted.

## Operation
- Field arithmetic:
  - GF(16) uses x^4+x+1.
  - GF(256) uses the AES polynomial x^8+x^4+x^3+x+1.
  - When `USE_TOWER_FIELD` is defined, the team's tower-field multipliers are used instead.
  - Addition is XOR; there is no carry and no width growth.
- Opcodes (k = latched key coefficient, acc = per-lane accumulator):
  - 0 NOP: no effect, no output.
  - 1 LOAD: acc <= data_in.
  - 2 MAC: acc[i] <= acc[i] ^ coef_in*data_in[i].
  - 3 MACK: acc[i] <= acc[i] ^ k*data_in[i].
  - 4 SETK: k <= coef_in.
  - 5 SCALE: outputs coef_in*data_in[i]; acc is unchanged.
  - 6 AXPY: outputs acc[i] ^ coef_in*data_in[i]; acc is unchanged.
  - 7 DRAIN: outputs acc, then acc <= 0.
  - 8..15: behave as NOP and set illegal_op.
- Only SCALE, AXPY and DRAIN produce a result beat (out_valid). All other opcodes retire silently.
- Effect ordering:
  - Products are formed at issue. k is the value in force at issue.
  - SETK updates k at its accept edge, so a MACK accepted on the very next cycle uses the new k.
  - acc reads and writes (LOAD, MAC, MACK, AXPY, DRAIN) happen only at the final pipeline stage, in accept order.
  - Because of this, back-to-back dependent ops need no stalls or forwarding.
- Backpressure:
  - The global advance enable is en = !out_valid || out_ready.
  - in_ready = en.
  - When en = 0, every pipeline stage, acc and out register hold.
  - Silent ops in flight are held as well.
- Reset clears:
  - acc and k to 0.
  - All stage valids to 0.
  - out_valid, data_out, op_out and illegal_op to 0.
  - In-flight beats are discarded, including when reset arrives mid-stream or while stalled.

## Timing
- Pipeline depth is D = MUL_STAGES+1 registered stages. The final stage is the acc/out update.
- A beat accepted at edge t updates acc and/or loads the out register at edge t+D-1.
  - The result is visible on data_out from edge t+D-1 onward.
  - With MUL_STAGES=0, the result is visible after the accept edge itself.
  - In the absence of stalls, out_valid rises D-1 cycles after the accept edge.
- Stall cycles add latency one-for-one. Ordering is always preserved.
- data_out, op_out and out_valid are registered and stay stable while out_valid && !out_ready.
- nz_mask is combinational from the acc register. It reflects acc after the most recent final-stage update.
- Throughput is one beat per cycle while out_ready = 1.
- Simultaneous DRAIN retire and MAC acceptance: the MAC lands after the clear, in the following final-stage slot.

## Test plan
- GF(16), LANES=4, MUL_STAGES=1, out_ready=1:
  - Stimulus: LOAD {1,2,3,4}; MAC coef 2, data {9,9,9,9}.
  - Required: nz_mask = 4'b1110 after the MAC retires.
  - Stimulus: DRAIN.
  - Required: data_out = {0,3,2,5}, then nz_mask = 0.
- GF(16) SETK/MACK hazard:
  - Stimulus: SETK 3 on cycle n; MACK data {7,7,7,7} on cycle n+1 (acc = 0); DRAIN.
  - Required: data_out = {9,9,9,9}.
- GF(256), LANES=2, MUL_STAGES=2:
  - Stimulus: SCALE coef 0x57, data {0x83,0x13}.
  - Required: {0xC1,0xFE}, out_valid exactly 2 cycles after accept.
  - Stimulus: AXPY with acc = {0x01,0x01}.
  - Required: {0xC0,0xFF}.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles during a stream of SCALE beats.
  - Required: in_ready=0 while out_valid; data_out stable; no beat lost or duplicated; order preserved after release.
- Reset and illegal opcode:
  - Stimulus: accept op 12.
  - Required: illegal_op=1 and no output.
  - Stimulus: assert rst while two MACs and a DRAIN are in flight.
  - Required: illegal_op=0, out_valid=0, nz_mask=0, and the next DRAIN outputs all zeros.

Source files
------------

// File: rtl/gf_pe_vec.sv
// gf_pe_vec: vectorised GF(2^m) processing element (bulk MAC / scale / drain).
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   input beat handshake (in_ready = global advance enable)
//   op_in, coef_in      opcode and scalar coefficient of the beat
//   data_in             LANES field elements, lane i at [i*GF_BIT +: GF_BIT]
//   out_valid/out_ready result beat handshake (SCALE, AXPY, DRAIN only)
//   op_out, data_out    registered opcode and vector of the result beat
//   nz_mask             bit i set when accumulator lane i is non-zero
//   illegal_op          sticky flag, set when an opcode 8..15 is accepted
//
// Products are formed at issue; the accumulator and output register are
// touched only in the final stage, so dependent beats flow back-to-back.
module gf_pe_vec #(
   parameter int unsigned GF_BIT      = 4,
   parameter int unsigned LANES       = 4,
   parameter int unsigned MUL_STAGES  = 1,
   parameter int unsigned OP_CODE_LEN = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [OP_CODE_LEN-1:0]  op_in,
   input  logic [GF_BIT-1:0]       coef_in,
   input  logic [LANES*GF_BIT-1:0] data_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OP_CODE_LEN-1:0]  op_out,
   output logic [LANES*GF_BIT-1:0] data_out,
   output logic [LANES-1:0]        nz_mask,
   output logic                    illegal_op
);

   localparam int unsigned VW = LANES * GF_BIT;

   // Reduction term of the field polynomial with the leading x^m dropped.
   localparam logic [GF_BIT-1:0] RED_POLY = (GF_BIT == 8) ? GF_BIT'(8'h1B) : GF_BIT'(4'h3);

   typedef enum logic [OP_CODE_LEN-1:0] {
      OP_NOP   = OP_CODE_LEN'(0),
      OP_LOAD  = OP_CODE_LEN'(1),
      OP_MAC   = OP_CODE_LEN'(2),
      OP_MACK  = OP_CODE_LEN'(3),
      OP_SETK  = OP_CODE_LEN'(4),
      OP_SCALE = OP_CODE_LEN'(5),
      OP_AXPY  = OP_CODE_LEN'(6),
      OP_DRAIN = OP_CODE_LEN'(7)
   } op_e;

   function automatic logic [GF_BIT-1:0] gf_mul(input logic [GF_BIT-1:0] a,
                                                input logic [GF_BIT-1:0] b);
      logic [GF_BIT-1:0] p;
      logic [GF_BIT-1:0] s;
      p = '0;
      s = a;
      for (int unsigned i = 0; i < GF_BIT; i++) begin
         if (b[i]) p = p ^ s;
         s = s[GF_BIT-1] ? ((s << 1) ^ RED_POLY) : (s << 1);
      end
      return p;
   endfunction

   logic                   en;
   logic                   accept;
   logic [GF_BIT-1:0]      k;
   logic [GF_BIT-1:0]      mul_coef;
   logic [VW-1:0]          prod_vec;
   logic [VW-1:0]          issue_vec;
   logic [VW-1:0]          acc;

   logic                   fin_valid;
   logic [OP_CODE_LEN-1:0] fin_op;
   logic [VW-1:0]          fin_vec;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   assign accept   = in_valid && en;

   // MACK samples k as it stands at issue, so a SETK one beat earlier is seen.
   assign mul_coef = (op_in == OP_MACK) ? k : coef_in;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
`ifdef USE_TOWER_FIELD
      gf_tower_mul #(.GF_BIT(GF_BIT)) u_mul (
         .a (mul_coef),
         .b (data_in[g*GF_BIT +: GF_BIT]),
         .p (prod_vec[g*GF_BIT +: GF_BIT])
      );
`else
      assign prod_vec[g*GF_BIT +: GF_BIT] = gf_mul(mul_coef, data_in[g*GF_BIT +: GF_BIT]);
`endif
      assign nz_mask[g] = |acc[g*GF_BIT +: GF_BIT];
   end

   // LOAD carries raw data through the pipe; every other op carries the product.
   assign issue_vec = (op_in == OP_LOAD) ? data_in : prod_vec;

   if (MUL_STAGES == 0) begin : g_direct
      assign fin_valid = accept;
      assign fin_op    = op_in;
      assign fin_vec   = issue_vec;
   end else begin : g_pipe
      logic [MUL_STAGES-1:0]  st_valid;
      logic [OP_CODE_LEN-1:0] st_op  [MUL_STAGES];
      logic [VW-1:0]          st_vec [MUL_STAGES];

      always_ff @(posedge clk) begin
         if (rst) begin
            st_valid <= '0;
            for (int unsigned i = 0; i < MUL_STAGES; i++) begin
               st_op[i]  <= '0;
               st_vec[i] <= '0;
            end
         end else if (en) begin
            st_valid[0] <= accept;
            st_op[0]    <= op_in;
            st_vec[0]   <= issue_vec;
            for (int unsigned i = 1; i < MUL_STAGES; i++) begin
               st_valid[i] <= st_valid[i-1];
               st_op[i]    <= st_op[i-1];
               st_vec[i]   <= st_vec[i-1];
            end
         end
      end

      assign fin_valid = st_valid[MUL_STAGES-1];
      assign fin_op    = st_op[MUL_STAGES-1];
      assign fin_vec   = st_vec[MUL_STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k <= '0;
      end else if (accept && (op_in == OP_SETK)) begin
         k <= coef_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         illegal_op <= 1'b0;
      end else if (accept && (op_in > OP_DRAIN)) begin
         illegal_op <= 1'b1;
      end
   end

   // Final stage: the only place acc is read or written.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         out_valid <= 1'b0;
         data_out  <= '0;
         op_out    <= '0;
      end else if (en) begin
         out_valid <= 1'b0;
         if (fin_valid) begin
            case (fin_op)
               OP_LOAD: acc <= fin_vec;
               OP_MAC,
               OP_MACK: acc <= acc ^ fin_vec;
               OP_SCALE: begin
                  out_valid <= 1'b1;
                  data_out  <= fin_vec;
                  op_out    <= fin_op;
               end
               OP_AXPY: begin
                  out_valid <= 1'b1;
                  data_out  <= acc ^ fin_vec;
                  op_out    <= fin_op;
               end
               OP_DRAIN: begin
                  out_valid <= 1'b1;
                  data_out  <= acc;
                  op_out    <= fin_op;
                  acc       <= '0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
